// File: rtl/timer_bank_pkg.sv
// Shared register map constants and helpers for the timer_bank block.
package timer_bank_pkg;

  localparam int unsigned CH_STRIDE = 16;

  localparam int unsigned TCON_EN   = 0;
  localparam int unsigned TCON_IE   = 1;
  localparam int unsigned TCON_FLAG = 2;
  localparam int unsigned TCON_MODE = 3;

  typedef enum logic [1:0] {
    REG_TH    = 2'd0,
    REG_TL    = 2'd1,
    REG_TCON  = 2'd2,
    REG_PRESC = 2'd3
  } reg_sel_e;

  function automatic logic [31:0] tcon_word(input logic en, input logic ie,
                                            input logic flag, input logic mode);
    logic [31:0] w;
    w            = '0;
    w[TCON_EN]   = en;
    w[TCON_IE]   = ie;
    w[TCON_FLAG] = flag;
    w[TCON_MODE] = mode;
    return w;
  endfunction

endpackage

// File: rtl/timer_bank_if.sv
// CPU data-bus view of the timer bank: strobes, address, data and window hit.
interface timer_bank_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;

  modport master (output rd, wr, addr, wdata, input rdata, hit);
  modport slave  (input rd, wr, addr, wdata, output rdata, hit);
endinterface

// File: rtl/timer_bank_channel.sv
// One timer channel: reload/count registers, control bits, prescaler and overflow flag.
module timer_bank_channel
  import timer_bank_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               cpu_clk,
  input  logic               reset,
  input  logic               th_we,
  input  logic               tl_we,
  input  logic               tcon_we,
  input  logic               presc_we,
  input  logic               flag_clr,
  input  logic [31:0]        wdata,
  output logic [CNT_W-1:0]   th,
  output logic [CNT_W-1:0]   tl,
  output logic [PRESC_W-1:0] presc,
  output logic               en,
  output logic               ie,
  output logic               flag,
  output logic               mode,
  output logic               irq
);

  logic [PRESC_W-1:0] pcnt;
  logic               tick;
  logic               ovf;

  assign tick = en && (pcnt == presc);
  // A TL write in the same cycle suppresses the overflow entirely (no reload, no flag).
  assign ovf  = tick && (&tl) && !tl_we;
  assign irq  = flag & ie;

  // Prescale counter: runs 0..PRESC while enabled, restarts on tick or PRESC write.
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset)        pcnt <= '0;
    else if (presc_we) pcnt <= '0;
    else if (tick)     pcnt <= '0;
    else if (en)       pcnt <= pcnt + PRESC_W'(1);
  end

  // Reload and prescale registers are plain CPU-loaded values.
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      th    <= '0;
      presc <= '0;
    end else begin
      if (th_we)    th    <= wdata[CNT_W-1:0];
      if (presc_we) presc <= wdata[PRESC_W-1:0];
    end
  end

  // Count register: CPU write beats the timer, overflow reloads from the old TH.
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset)     tl <= '0;
    else if (tl_we) tl <= wdata[CNT_W-1:0];
    else if (ovf)   tl <= th;
    else if (tick)  tl <= tl + CNT_W'(1);
  end

  // Control bits: write loads EN/IE/MODE; one-shot overflow drops EN.
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      en   <= 1'b0;
      ie   <= 1'b0;
      mode <= 1'b0;
    end else if (tcon_we) begin
      en   <= wdata[TCON_EN];
      ie   <= wdata[TCON_IE];
      mode <= wdata[TCON_MODE];
    end else if (ovf && mode) begin
      en   <= 1'b0;
    end
  end

  // Overflow flag: a set in the same cycle as a clear keeps the flag high.
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset)        flag <= 1'b0;
    else if (ovf)      flag <= 1'b1;
    else if (flag_clr) flag <= 1'b0;
  end

endmodule

// File: rtl/timer_bank.sv
// N-channel memory-mapped timer bank: address decode, read mux, status word, irq reduction.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int unsigned N_TIMERS  = 4,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned PRESC_W   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0100
) (
  input  logic                cpu_clk,
  input  logic                reset,
  timer_bank_if.slave         bus,
  output logic [N_TIMERS-1:0] irq,
  output logic                irqout
);

  localparam logic [31:0] WIN_BYTES = 32'(CH_STRIDE * N_TIMERS + 4);
  localparam logic [27:0] STAT_IDX  = 28'(N_TIMERS);

  logic [31:0]        off;
  logic               in_win;
  logic               aligned;
  logic [27:0]        blk;
  reg_sel_e           rsel;
  logic               stat_sel;
  logic               stat_we;
  logic [31:0]        rdata_c;

  logic [CNT_W-1:0]   th    [N_TIMERS];
  logic [CNT_W-1:0]   tl    [N_TIMERS];
  logic [PRESC_W-1:0] presc [N_TIMERS];
  logic [N_TIMERS-1:0] en, ie, flag, mode;

  assign off      = bus.addr - BASE_ADDR;
  assign in_win   = (bus.addr >= BASE_ADDR) && (off < WIN_BYTES);
  assign aligned  = in_win && (off[1:0] == 2'b00);
  assign blk      = off[31:4];
  assign rsel     = reg_sel_e'(off[3:2]);
  assign stat_sel = aligned && (blk == STAT_IDX) && (off[3:2] == 2'b00);
  assign stat_we  = bus.wr && stat_sel;
  assign bus.hit  = in_win;

  for (genvar g = 0; g < N_TIMERS; g++) begin : g_ch
    logic ch_sel;
    logic th_we, tl_we, tcon_we, presc_we, flag_clr;

    assign ch_sel   = aligned && (blk == 28'(g));
    assign th_we    = bus.wr && ch_sel && (rsel == REG_TH);
    assign tl_we    = bus.wr && ch_sel && (rsel == REG_TL);
    assign tcon_we  = bus.wr && ch_sel && (rsel == REG_TCON);
    assign presc_we = bus.wr && ch_sel && (rsel == REG_PRESC);
    assign flag_clr = (tcon_we && bus.wdata[TCON_FLAG]) || (stat_we && bus.wdata[g]);

    timer_bank_channel #(
      .CNT_W   (CNT_W),
      .PRESC_W (PRESC_W)
    ) u_ch (
      .cpu_clk  (cpu_clk),
      .reset    (reset),
      .th_we    (th_we),
      .tl_we    (tl_we),
      .tcon_we  (tcon_we),
      .presc_we (presc_we),
      .flag_clr (flag_clr),
      .wdata    (bus.wdata),
      .th       (th[g]),
      .tl       (tl[g]),
      .presc    (presc[g]),
      .en       (en[g]),
      .ie       (ie[g]),
      .flag     (flag[g]),
      .mode     (mode[g]),
      .irq      (irq[g])
    );
  end

  // Read mux: only aligned, mapped words return data; everything else reads zero.
  always_comb begin
    rdata_c = '0;
    if (bus.rd && aligned) begin
      if (stat_sel) rdata_c = 32'(flag);
      for (int i = 0; i < N_TIMERS; i++) begin
        if (blk == 28'(i)) begin
          case (rsel)
            REG_TH:    rdata_c = 32'(th[i]);
            REG_TL:    rdata_c = 32'(tl[i]);
            REG_TCON:  rdata_c = tcon_word(en[i], ie[i], flag[i], mode[i]);
            REG_PRESC: rdata_c = 32'(presc[i]);
            default:   rdata_c = '0;
          endcase
        end
      end
    end
  end

  assign bus.rdata = rdata_c;
  assign irqout    = |irq;

endmodule

// File: tb/tb_timer_bank.sv
module tb_timer_bank;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h4000_0100;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic       cpu_clk = 1'b0;
  logic       reset   = 1'b0;
  logic [3:0] irq;
  logic       irqout;

  timer_bank_if bus();

  timer_bank #(
    .N_TIMERS  (N),
    .CNT_W     (32),
    .PRESC_W   (8),
    .BASE_ADDR (BASE)
  ) dut (
    .cpu_clk (cpu_clk),
    .reset   (reset),
    .bus     (bus),
    .irq     (irq),
    .irqout  (irqout)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: per-channel register contents as plain arrays.
  logic [31:0] m_th [N];
  logic [31:0] m_tl [N];
  logic [7:0]  m_presc [N];
  logic [7:0]  m_pcnt [N];
  bit          m_en [N];
  bit          m_ie [N];
  bit          m_flag [N];
  bit          m_mode [N];

  logic [31:0] last_rdata;
  logic [3:0]  last_irq;
  logic        last_irqout;

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      m_th[c] = '0; m_tl[c] = '0; m_presc[c] = '0; m_pcnt[c] = '0;
      m_en[c] = 0; m_ie[c] = 0; m_flag[c] = 0; m_mode[c] = 0;
    end
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off >= 0) && (off < 16 * N + 4);
  endfunction

  function automatic logic [3:0] model_irq();
    logic [3:0] v;
    for (int c = 0; c < N; c++) v[c] = m_flag[c] & m_ie[c];
    return v;
  endfunction

  function automatic logic [31:0] model_read(input bit r, input logic [31:0] a);
    longint off;
    int ch, rg;
    logic [31:0] v;
    off = longint'(a) - longint'(BASE);
    if (!r || off < 0 || off >= 16 * N + 4 || (off % 4) != 0) return 32'h0;
    ch = int'(off / 16);
    rg = int'((off % 16) / 4);
    v = '0;
    if (ch == N) begin
      for (int c = 0; c < N; c++) v[c] = m_flag[c];
    end else begin
      case (rg)
        0: v = m_th[ch];
        1: v = m_tl[ch];
        2: v = {28'h0, m_mode[ch], m_flag[ch], m_ie[ch], m_en[ch]};
        default: v = {24'h0, m_presc[ch]};
      endcase
    end
    return v;
  endfunction

  // One clock edge of the timer bank, straight from the register behaviour rules.
  function automatic void model_clock(input bit w, input logic [31:0] a, input logic [31:0] d);
    longint off;
    int wch, wrg, tw;
    bit stat_w, tick, ovf, clr, wrap;
    off = longint'(a) - longint'(BASE);
    wch = -1; wrg = -1; stat_w = 0;
    if (w && off >= 0 && off < 16 * N + 4 && (off % 4) == 0) begin
      if (off == 16 * N) stat_w = 1;
      else begin
        wch = int'(off / 16);
        wrg = int'((off % 16) / 4);
      end
    end
    for (int c = 0; c < N; c++) begin
      tw   = (wch == c) ? wrg : -1;
      tick = m_en[c] && (m_pcnt[c] == m_presc[c]);
      wrap = (m_tl[c] == ONES);
      ovf  = tick && wrap && (tw != 1);
      clr  = (tw == 2 && d[2]) || (stat_w && d[c]);

      if (tw == 1)   m_tl[c] = d;
      else if (ovf)  m_tl[c] = m_th[c];
      else if (tick) m_tl[c] = m_tl[c] + 1;

      if (tw == 3 || tick) m_pcnt[c] = 8'h0;
      else if (m_en[c])    m_pcnt[c] = m_pcnt[c] + 8'h1;

      if (ovf)      m_flag[c] = 1;
      else if (clr) m_flag[c] = 0;

      if (tw == 2) begin
        m_en[c] = d[0]; m_ie[c] = d[1]; m_mode[c] = d[3];
      end else if (ovf && m_mode[c]) begin
        m_en[c] = 0;
      end

      if (tw == 0) m_th[c] = d;
      if (tw == 3) m_presc[c] = d[7:0];
    end
  endfunction

  task automatic bus_cycle(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    @(negedge cpu_clk);
    bus.rd = r; bus.wr = w; bus.addr = a; bus.wdata = d;
    #1;
    last_rdata  = bus.rdata;
    last_irq    = irq;
    last_irqout = irqout;
    chk("hit", 32'(bus.hit), 32'(model_hit(a)));
    chk("rdata", bus.rdata, model_read(r, a));
    chk("irq", 32'(irq), 32'(model_irq()));
    chk("irqout", 32'(irqout), 32'(model_irq() != 4'h0));
    model_clock(w, a, d);
  endtask

  function automatic logic [31:0] reg_addr(input int ch, input int rg);
    return BASE + 32'(16 * ch + 4 * rg);
  endfunction

  task automatic wr_reg(input int ch, input int rg, input logic [31:0] d);
    bus_cycle(0, 1, reg_addr(ch, rg), d);
  endtask

  task automatic rd_exp(input string tag, input int ch, input int rg, input logic [31:0] exp);
    bus_cycle(1, 0, reg_addr(ch, rg), 32'h0);
    chk(tag, last_rdata, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      bus_cycle(0, 0, BASE - 32'd64 + 32'($urandom_range(0, 200)), $urandom);
  endtask

  task automatic do_reset();
    @(negedge cpu_clk);
    bus.rd = 0; bus.wr = 0;
    reset = 0;
    #1;
    model_reset();
    chk("reset_irqout", 32'(irqout), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    @(negedge cpu_clk);
    reset = 1;
  endtask

  initial begin
    int op, ch, rg;
    logic [31:0] d, a;

    bus.rd = 0; bus.wr = 0; bus.addr = '0; bus.wdata = '0;
    model_reset();
    repeat (3) @(negedge cpu_clk);
    reset = 1;

    for (int c = 0; c <= N; c++)
      for (int r = 0; r < ((c == N) ? 1 : 4); r++)
        rd_exp("reset_reg", c, r, 32'h0);

    // Auto-reload overflow with interrupt on channel 0.
    wr_reg(0, 0, 32'hFFFF_FFFD);
    wr_reg(0, 1, 32'hFFFF_FFFD);
    wr_reg(0, 3, 32'h0);
    wr_reg(0, 2, 32'h3);
    idle(3);
    rd_exp("ch0_tl_reload", 0, 1, 32'hFFFF_FFFD);
    chk("ch0_irqout", 32'(last_irqout), 32'h1);
    rd_exp("ch0_tcon_flag", 0, 2, 32'h7);
    wr_reg(0, 2, 32'h2);

    // Prescaled counting on channel 1.
    wr_reg(1, 3, 32'h3);
    wr_reg(1, 1, 32'h0);
    wr_reg(1, 2, 32'h1);
    idle(20);
    rd_exp("ch1_presc_count", 1, 1, 32'h5);

    // One-shot on channel 2.
    wr_reg(2, 0, 32'h10);
    wr_reg(2, 1, ONES);
    wr_reg(2, 2, 32'h9);
    idle(1);
    rd_exp("ch2_oneshot_tl", 2, 1, 32'h10);
    rd_exp("ch2_oneshot_tcon", 2, 2, 32'hC);
    idle(3);
    rd_exp("ch2_oneshot_held", 2, 1, 32'h10);
    wr_reg(2, 2, 32'h4);

    // Status clear of channel 0 while channel 3 stays flagged.
    wr_reg(3, 1, ONES);
    wr_reg(3, 2, 32'hB);
    idle(1);
    wr_reg(N, 0, 32'h1);
    rd_exp("stat_after_clear", N, 0, 32'h8);
    chk("irq_after_clear", 32'(last_irq), 32'h8);
    wr_reg(N, 0, 32'h8);

    // TL write on the overflow edge wins.
    wr_reg(0, 3, 32'h0);
    wr_reg(0, 1, ONES);
    wr_reg(0, 2, 32'h3);
    wr_reg(0, 1, 32'h55);
    rd_exp("tl_write_wins", 0, 1, 32'h55);
    rd_exp("tl_write_noflag", 0, 2, 32'h3);

    // Flag set on the same edge as a STAT clear survives.
    wr_reg(0, 1, ONES);
    wr_reg(N, 0, 32'h1);
    rd_exp("set_beats_clear", 0, 2, 32'h7);

    // Reset mid-count with flags pending.
    do_reset();
    for (int c = 0; c <= N; c++)
      for (int r = 0; r < ((c == N) ? 1 : 4); r++)
        rd_exp("midreset_reg", c, r, 32'h0);
    bus_cycle(1, 0, BASE + 32'h42, 32'h0);
    chk("unmapped_rdata", last_rdata, 32'h0);
    chk("post_reset_irqout", 32'(last_irqout), 32'h0);

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      if (k % 700 == 699) do_reset();
      op = int'($urandom_range(0, 9));
      ch = int'($urandom_range(0, N));
      rg = (ch == N) ? 0 : int'($urandom_range(0, 3));
      if (ch == N)     d = 32'($urandom_range(0, 15));
      else if (rg == 1) d = ($urandom_range(0, 3) == 0) ? $urandom : ONES - 32'($urandom_range(0, 6));
      else if (rg == 2) d = 32'($urandom_range(0, 15));
      else if (rg == 3) d = 32'($urandom_range(0, 3));
      else              d = $urandom;
      a = reg_addr(ch, rg);
      case (op)
        0, 1, 2: bus_cycle(0, 1, a, d);
        3, 4, 5: bus_cycle(1, 0, a, d);
        6:       bus_cycle(1, 1, a, d);
        7:       bus_cycle(1, $urandom_range(0, 1) == 1,
                           BASE - 32'd32 + 32'($urandom_range(0, 128)), d);
        default: idle(1);
      endcase
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
